wb_stage_reg: RTL and testbench

- Parametrised successor to the combinational writeback mux.
- Combines the MEM/WB pipeline register with writeback selection.
- Adds byte/halfword load extraction with sign/zero extension, stall/flush control, r0 write suppression and a retired-instruction counter.
- Sits between the memory stage and the register file write port; its outputs also feed the forwarding unit.

---
 rtl/wb_stage_reg.sv | 98 +++++++++
 tb/tb_wb_stage_reg.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_stage_reg
//  Purpose  : MEM/WB pipeline register with writeback selection, sub-word
//             load extraction, stall/flush control and retired counter.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_stage_reg #(
    parameter int WORD_LEN     = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int CNT_LEN      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    freeze,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic                    in_wb_en,
    input  logic                    in_mem_r_en,
    input  logic [REG_ADDR_LEN-1:0] in_dest,
    input  logic [WORD_LEN-1:0]     in_alu_res,
    input  logic [WORD_LEN-1:0]     in_mem_data,
    input  logic [1:0]              in_load_size,
    input  logic                    in_load_signed,
    input  logic [1:0]              in_byte_off,
    output logic                    wb_valid,
    output logic                    wb_en,
    output logic [REG_ADDR_LEN-1:0] wb_dest,
    output logic [WORD_LEN-1:0]     wb_value,
    output logic [CNT_LEN-1:0]      retired_cnt
);

    localparam int c_LANE_W = 32;

    logic [c_LANE_W-1:0]     w_mem32;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [WORD_LEN-1:0]     w_sel;

    logic                    r_wb_valid;
    logic                    r_wb_en;
    logic [REG_ADDR_LEN-1:0] r_wb_dest;
    logic [WORD_LEN-1:0]     r_wb_value;
    logic [CNT_LEN-1:0]      r_retired_cnt;

    // Sub-word lanes always come from the low 32 bits; narrow words are padded
    // so every byte offset stays in range.
    generate
        if (WORD_LEN >= c_LANE_W) begin : g_wide
            assign w_mem32 = in_mem_data[c_LANE_W-1:0];
        end else begin : g_narrow
            assign w_mem32 = {{(c_LANE_W-WORD_LEN){1'b0}}, in_mem_data};
        end
    endgenerate

    always_comb begin
        w_byte = w_mem32[{in_byte_off, 3'b000} +: 8];
        w_half = w_mem32[{in_byte_off[1], 4'b0000} +: 16];
        w_sel  = in_alu_res;
        if (in_mem_r_en) begin
            case (in_load_size)
                2'b00:   w_sel = {{(WORD_LEN-8){in_load_signed & w_byte[7]}}, w_byte};
                2'b01:   w_sel = {{(WORD_LEN-16){in_load_signed & w_half[15]}}, w_half};
                default: w_sel = in_mem_data;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_valid    <= 1'b0;
            r_wb_en       <= 1'b0;
            r_wb_dest     <= '0;
            r_wb_value    <= '0;
            r_retired_cnt <= '0;
        end else if (flush) begin
            // Bubble: the counter is deliberately left alone.
            r_wb_valid <= 1'b0;
            r_wb_en    <= 1'b0;
            r_wb_dest  <= '0;
            r_wb_value <= '0;
        end else if (!freeze) begin
            r_wb_valid    <= in_valid;
            r_wb_en       <= in_valid & in_wb_en & (in_dest != '0);
            r_wb_dest     <= in_dest;
            r_wb_value    <= w_sel;
            r_retired_cnt <= r_retired_cnt + {{(CNT_LEN-1){1'b0}}, in_valid};
        end
    end

    assign wb_valid    = r_wb_valid;
    assign wb_en       = r_wb_en;
    assign wb_dest     = r_wb_dest;
    assign wb_value    = r_wb_value;
    assign retired_cnt = r_retired_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_stage_reg
//  Purpose  : Randomised self-checking bench for wb_stage_reg against a
//             behavioural reference model, plus directed literal checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage_reg;

    localparam int WORD_LEN     = 32;
    localparam int REG_ADDR_LEN = 5;
    localparam int CNT_LEN      = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_wb_en = 1'b0;
    logic        in_mem_r_en = 1'b0;
    logic [4:0]  in_dest = '0;
    logic [31:0] in_alu_res = '0;
    logic [31:0] in_mem_data = '0;
    logic [1:0]  in_load_size = '0;
    logic        in_load_signed = 1'b0;
    logic [1:0]  in_byte_off = '0;

    logic        wb_valid;
    logic        wb_en;
    logic [4:0]  wb_dest;
    logic [31:0] wb_value;
    logic [3:0]  retired_cnt;

    int errors = 0;
    int checks = 0;

    wb_stage_reg #(
        .WORD_LEN    (WORD_LEN),
        .REG_ADDR_LEN(REG_ADDR_LEN),
        .CNT_LEN     (CNT_LEN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .freeze        (freeze),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_wb_en      (in_wb_en),
        .in_mem_r_en   (in_mem_r_en),
        .in_dest       (in_dest),
        .in_alu_res    (in_alu_res),
        .in_mem_data   (in_mem_data),
        .in_load_size  (in_load_size),
        .in_load_signed(in_load_signed),
        .in_byte_off   (in_byte_off),
        .wb_valid      (wb_valid),
        .wb_en         (wb_en),
        .wb_dest       (wb_dest),
        .wb_value      (wb_value),
        .retired_cnt   (retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: value selection from shifts and masks on the full word.
    function automatic logic [31:0] model_sel(input logic mr, input logic [31:0] alu,
                                              input logic [31:0] mem, input logic [1:0] sz,
                                              input logic sg, input logic [1:0] off);
        logic [31:0] v;
        if (!mr) return alu;
        if (sz == 2'd0) begin
            v = (mem >> (8 * off)) & 32'h0000_00FF;
            if (sg && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (mem >> (16 * off[1])) & 32'h0000_FFFF;
            if (sg && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = mem;
        end
        return v;
    endfunction

    logic        m_live = 1'b0;
    logic        m_valid, m_en;
    logic [4:0]  m_dest;
    logic [31:0] m_value;
    int          m_cnt;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b0; m_en = 1'b0; m_dest = '0; m_value = '0; m_cnt = 0;
            m_live  = 1'b1;
        end else if (flush) begin
            m_valid = 1'b0; m_en = 1'b0; m_dest = '0; m_value = '0;
        end else if (!freeze) begin
            m_valid = in_valid;
            m_en    = in_valid && in_wb_en && (in_dest != 5'd0);
            m_dest  = in_dest;
            m_value = model_sel(in_mem_r_en, in_alu_res, in_mem_data,
                                in_load_size, in_load_signed, in_byte_off);
            m_cnt   = (m_cnt + int'(in_valid)) % (1 << CNT_LEN);
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("wb_valid", 32'(wb_valid), 32'(m_valid));
            chk("wb_en", 32'(wb_en), 32'(m_en));
            chk("wb_dest", 32'(wb_dest), 32'(m_dest));
            chk("wb_value", wb_value, m_value);
            chk("retired_cnt", 32'(retired_cnt), 32'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic mr, input logic [4:0] d,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [1:0] sz, input logic sg, input logic [1:0] off);
        in_valid = v; in_wb_en = we; in_mem_r_en = mr; in_dest = d;
        in_alu_res = alu; in_mem_data = mem; in_load_size = sz;
        in_load_signed = sg; in_byte_off = off;
    endtask

    task automatic drive_random();
        drive(1'($urandom), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
              $urandom, $urandom, 2'($urandom), 1'($urandom), 2'($urandom));
    endtask

    logic [1:0]  ld_sz  [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
    logic        ld_sg  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0]  ld_off [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
    logic [31:0] ld_exp [5] = '{32'hFFFF_FF82, 32'h0000_007F, 32'hFFFF_80F1,
                                32'h0000_80F1, 32'h80F1_7F82};

    initial begin
        int nvalid;
        // Reset with garbage inputs, including a simultaneous freeze/flush.
        drive_random();
        freeze = 1'b1;
        tick();
        chk("rst_valid", 32'(wb_valid), 32'd0);
        chk("rst_en", 32'(wb_en), 32'd0);
        chk("rst_dest", 32'(wb_dest), 32'd0);
        chk("rst_value", wb_value, 32'd0);
        chk("rst_cnt", 32'(retired_cnt), 32'd0);
        drive_random();
        flush = 1'b1;
        tick();
        rst = 1'b0; freeze = 1'b0; flush = 1'b0;

        drive(1, 1, 0, 5'd5, 32'h1234_5678, 32'hDEAD_BEEF, 2'd0, 1, 2'd3);
        tick();
        chk("alu_en", 32'(wb_en), 32'd1);
        chk("alu_dest", 32'(wb_dest), 32'd5);
        chk("alu_value", wb_value, 32'h1234_5678);
        chk("alu_cnt", 32'(retired_cnt), 32'd1);

        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 1, 5'd9, 32'h5555_AAAA, 32'h80F1_7F82, ld_sz[i], ld_sg[i], ld_off[i]);
            tick();
            chk($sformatf("load%0d_value", i), wb_value, ld_exp[i]);
        end

        drive(1, 1, 0, 5'd0, 32'h0000_0001, 32'h0, 2'd2, 0, 2'd0);
        tick();
        chk("r0_valid", 32'(wb_valid), 32'd1);
        chk("r0_en", 32'(wb_en), 32'd0);
        chk("r0_cnt", 32'(retired_cnt), 32'd7);

        drive(1, 1, 0, 5'd7, 32'h0000_000A, 32'h0, 2'd2, 0, 2'd0);
        tick();
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_random();
            tick();
            chk("frz_dest", 32'(wb_dest), 32'd7);
            chk("frz_value", wb_value, 32'h0000_000A);
            chk("frz_cnt", 32'(retired_cnt), 32'd8);
        end
        flush = 1'b1;
        drive_random();
        tick();
        chk("fl_valid", 32'(wb_valid), 32'd0);
        chk("fl_en", 32'(wb_en), 32'd0);
        chk("fl_value", wb_value, 32'd0);
        chk("fl_cnt", 32'(retired_cnt), 32'd8);
        freeze = 1'b0; flush = 1'b0;

        // Counter wrap: 17 valid captures with bubbles interleaved.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nvalid = 0;
        while (nvalid < 17) begin
            drive_random();
            in_valid = 1'b1;
            tick();
            nvalid++;
            if (nvalid % 3 == 0) begin
                drive_random();
                in_valid = 1'b0;
                tick();
            end
            if (nvalid == 16) chk("wrap16_cnt", 32'(retired_cnt), 32'd0);
        end
        chk("wrap17_cnt", 32'(retired_cnt), 32'd1);

        for (int i = 0; i < 400; i++) begin
            drive_random();
            rst    = ($urandom_range(0, 49) == 0);
            flush  = ($urandom_range(0, 9) == 0);
            freeze = ($urandom_range(0, 4) == 0);
            tick();
        end
        rst = 1'b0; flush = 1'b0; freeze = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
